// File: rtl/npu_input_stager_pkg.sv
// Shared types and sizing for the NPU input stager: lane count, index width
// and the dispatch FSM state encoding.
package npu_stager_pkg;

    localparam int LANES = 4;
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_BUSY = 2'b01,
        ST_RUN       = 2'b10
    } disp_state_e;

endpackage

// File: rtl/npu_input_stager_if.sv
// Byte-serial valid/ready stream from the host into the stager.
interface npu_input_stager_if;

    logic [7:0] S_DATA;
    logic       S_VALID;
    logic       S_LAST;
    logic       S_READY;

    modport master (output S_DATA, output S_VALID, output S_LAST, input S_READY);
    modport slave  (input S_DATA, input S_VALID, input S_LAST, output S_READY);

endinterface

// File: rtl/npu_input_stager_quad_packer.sv
// One-quad staging buffer: packs stream bytes into lanes A..D, zero-pads a
// quad closed early by S_LAST, and releases the buffer when the FSM takes it.
module quad_packer
    import npu_stager_pkg::*;
(
    input  logic                   CLKEXT,
    input  logic                   RST_GLO_N,
    npu_input_stager_if.slave      s_if,
    input  logic                   take,
    output logic                   stg_full,
    output logic                   pad_evt,
    output logic [LANES-1:0][7:0]  quad
);

    logic [LANES-1:0][7:0] stg;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  last_lane;

    assign s_if.S_READY = !stg_full;
    assign accept       = s_if.S_VALID && !stg_full;
    assign last_lane    = (idx == IDX_W'(LANES - 1));
    assign pad_evt      = accept && s_if.S_LAST && !last_lane;
    assign quad         = stg;

    always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
        if (!RST_GLO_N) begin
            // NOTE: the buffer is only four bytes, so it is reset outright; a partial quad never survives reset.
            stg      <= '0;
            idx      <= '0;
            stg_full <= 1'b0;
        end else begin
            // take and accept are exclusive: take needs a full buffer, accept an empty one
            if (take) begin
                stg_full <= 1'b0;
            end
            if (accept) begin
                stg[idx] <= s_if.S_DATA;
                if (last_lane || s_if.S_LAST) begin
                    stg_full <= 1'b1;
                    idx      <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        if (i > int'(idx)) begin
                            stg[i] <= '0;
                        end
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/npu_input_stager.sv
// NPU input stager top: dispatch FSM pacing quads to the core by BUSY/DONE,
// registered lane outputs, START pulse, dispatch counter and sticky errors.
module npu_input_stager
    import npu_stager_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_W       = 16
) (
    input  logic              CLKEXT,
    input  logic              RST_GLO_N,
    npu_input_stager_if.slave s_if,
    input  logic              CORE_BUSY,
    input  logic              CORE_DONE,
    input  logic              CLR_ERR,
    output logic [7:0]        DA,
    output logic [7:0]        DB,
    output logic [7:0]        DC,
    output logic [7:0]        DD,
    output logic              START,
    output logic [CNT_W-1:0]  QUAD_CNT,
    output logic              ERR_PAD,
    output logic              ERR_TIMEOUT
);

    localparam int TC_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    disp_state_e           state;
    logic [TC_W-1:0]       tcnt;
    logic                  stg_full;
    logic                  pad_evt;
    logic                  take;
    logic                  timeout_hit;
    logic [LANES-1:0][7:0] quad;

    quad_packer u_packer (
        .CLKEXT    (CLKEXT),
        .RST_GLO_N (RST_GLO_N),
        .s_if      (s_if),
        .take      (take),
        .stg_full  (stg_full),
        .pad_evt   (pad_evt),
        .quad      (quad)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        take        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE:      take        = stg_full;
            ST_WAIT_BUSY: timeout_hit = !CORE_BUSY && !CORE_DONE &&
                                        (tcnt == TC_W'(ACK_TIMEOUT - 1));
            default:      ;
        endcase
    end

    always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
        if (!RST_GLO_N) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            DA       <= '0;
            DB       <= '0;
            DC       <= '0;
            DD       <= '0;
            START    <= 1'b0;
            QUAD_CNT <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every register here updates from pre-edge values.
            START <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        DA       <= quad[0];
                        DB       <= quad[1];
                        DC       <= quad[2];
                        DD       <= quad[3];
                        START    <= 1'b1;
                        QUAD_CNT <= QUAD_CNT + CNT_W'(1);
                        tcnt     <= '0;
                        state    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    tcnt <= tcnt + TC_W'(1);
                    // a core that finishes before BUSY is ever seen still counts as acknowledged
                    if (CORE_BUSY) begin
                        state <= ST_RUN;
                    end else if (CORE_DONE || timeout_hit) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (CORE_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // set events take priority over a coincident clear
    always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
        if (!RST_GLO_N) begin
            ERR_PAD     <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            if (pad_evt) begin
                ERR_PAD <= 1'b1;
            end else if (CLR_ERR) begin
                ERR_PAD <= 1'b0;
            end
            if (timeout_hit) begin
                ERR_TIMEOUT <= 1'b1;
            end else if (CLR_ERR) begin
                ERR_TIMEOUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_npu_input_stager.sv
// Directed bench for npu_input_stager: table of quads plus hand sequences for
// back-to-back dispatch, timeout, error clear priority and mid-quad reset.
module tb_npu_input_stager;

    logic CLKEXT    = 1'b0;
    logic RST_GLO_N = 1'b0;
    logic CORE_BUSY = 1'b0;
    logic CORE_DONE = 1'b0;
    logic CLR_ERR   = 1'b0;

    always #5 CLKEXT = ~CLKEXT;

    npu_input_stager_if sif ();
    npu_input_stager_if sif2 ();

    // second instance with a 2-bit counter shares all stimulus and shows the wrap
    assign sif2.S_DATA  = sif.S_DATA;
    assign sif2.S_VALID = sif.S_VALID;
    assign sif2.S_LAST  = sif.S_LAST;

    logic [7:0]  DA, DB, DC, DD;
    logic        START, ERR_PAD, ERR_TIMEOUT;
    logic [15:0] QUAD_CNT;
    logic [7:0]  DA2, DB2, DC2, DD2;
    logic        START2, ERR_PAD2, ERR_TIMEOUT2;
    logic [1:0]  QC2;

    npu_input_stager #(.ACK_TIMEOUT(4), .CNT_W(16)) dut (
        .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .s_if(sif),
        .CORE_BUSY(CORE_BUSY), .CORE_DONE(CORE_DONE), .CLR_ERR(CLR_ERR),
        .DA(DA), .DB(DB), .DC(DC), .DD(DD), .START(START),
        .QUAD_CNT(QUAD_CNT), .ERR_PAD(ERR_PAD), .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    npu_input_stager #(.ACK_TIMEOUT(4), .CNT_W(2)) dut2 (
        .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .s_if(sif2),
        .CORE_BUSY(CORE_BUSY), .CORE_DONE(CORE_DONE), .CLR_ERR(CLR_ERR),
        .DA(DA2), .DB(DB2), .DC(DC2), .DD(DD2), .START(START2),
        .QUAD_CNT(QC2), .ERR_PAD(ERR_PAD2), .ERR_TIMEOUT(ERR_TIMEOUT2)
    );

    typedef struct {
        logic [31:0] bytes;   // first byte in bits 31:24
        int          n;
        logic        last;
        int          run;     // core BUSY cycles; 0 means DONE without BUSY
        logic [31:0] lanes;   // expected {DA,DB,DC,DD}
        logic        pad;
    } vec_t;

    vec_t        vecs [7];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKEXT);
        #1;
    endtask

    task automatic check_cnt(input string name);
        check({name, "_cnt"}, QUAD_CNT, exp_cnt);
        check({name, "_cnt_w2"}, QC2, exp_cnt[1:0]);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        sif.S_DATA  = d;
        sif.S_VALID = 1'b1;
        sif.S_LAST  = last;
        while (sif.S_READY !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check("send_ready_timeout", sif.S_READY, 1);
        step();
        sif.S_VALID = 1'b0;
        sif.S_LAST  = 1'b0;
    endtask

    task automatic send_bytes(input logic [31:0] data, input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            send_byte(data[31-8*i -: 8], last && (i == n - 1));
        end
    endtask

    // called in the cycle START is high; BUSY follows two cycles later
    task automatic core_respond(input int run);
        step();
        check("start_pulse_width", START, 0);
        step();
        if (run > 0) begin
            CORE_BUSY = 1'b1;
            repeat (run) step();
            CORE_BUSY = 1'b0;
        end
        CORE_DONE = 1'b1;
        step();
        CORE_DONE = 1'b0;
    endtask

    task automatic run_quad(input vec_t v);
        send_bytes(v.bytes, v.n, v.last);
        check("ready_drop", sif.S_READY, 0);
        check("pad_flag", ERR_PAD, v.pad);
        check("start_not_early", START, 0);
        step();
        exp_cnt++;
        check("start_latency", START, 1);
        check("lanes", {DA, DB, DC, DD}, v.lanes);
        check("ready_after_dispatch", sif.S_READY, 1);
        check_cnt("dispatch");
        check("dut2_mirror", {DA2, DB2, DC2, DD2, START2, ERR_PAD2, ERR_TIMEOUT2, sif2.S_READY},
              {v.lanes, 1'b1, v.pad, 1'b0, 1'b1});
        core_respond(v.run);
        check("lanes_stable", {DA, DB, DC, DD}, v.lanes);
        check("no_timeout", ERR_TIMEOUT, 0);
        if (v.pad) begin
            CLR_ERR = 1'b1;
            step();
            CLR_ERR = 1'b0;
            check("pad_cleared", ERR_PAD, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q1, q2, q3;
        sif.S_DATA  = '0;
        sif.S_VALID = 1'b0;
        sif.S_LAST  = 1'b0;

        vecs[0] = '{32'h11223344, 4, 1'b0, 8, 32'h11223344, 1'b0};
        vecs[1] = '{32'hAABB0000, 2, 1'b1, 2, 32'hAABB0000, 1'b1};
        vecs[2] = '{32'h5A000000, 1, 1'b1, 0, 32'h5A000000, 1'b1};
        vecs[3] = '{32'h010203FE, 4, 1'b1, 3, 32'h010203FE, 1'b0};
        vecs[4] = '{32'hC33C7700, 3, 1'b1, 5, 32'hC33C7700, 1'b1};
        vecs[5] = '{32'h66778899, 4, 1'b0, 2, 32'h66778899, 1'b0};
        vecs[6] = '{32'h55667788, 4, 1'b0, 2, 32'h55667788, 1'b0};

        // reset values, sampled while reset is held
        #12;
        check("rst_lanes", {DA, DB, DC, DD}, 0);
        check("rst_start", START, 0);
        check("rst_cnt", QUAD_CNT, 0);
        check("rst_errs", {ERR_PAD, ERR_TIMEOUT}, 0);
        check("rst_ready", sif.S_READY, 1);
        RST_GLO_N = 1'b1;
        step();
        check("ready_after_rst", sif.S_READY, 1);

        for (int i = 0; i < 5; i++) begin
            run_quad(vecs[i]);
        end

        // back-to-back: Q2 fills during RUN, Q3 waits on a held byte
        q1 = 32'h10203040;
        q2 = 32'hA1A2A3A4;
        q3 = 32'hB1B2B3B4;
        send_bytes(q1, 4, 1'b0);
        step();
        exp_cnt++;
        check("b2b_start1", START, 1);
        check_cnt("b2b_q1");
        step();
        step();
        CORE_BUSY = 1'b1;
        step();
        send_bytes(q2, 4, 1'b0);
        check("b2b_ready_low", sif.S_READY, 0);
        sif.S_DATA  = q3[31:24];
        sif.S_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("b2b_hold", {sif.S_READY, START, DA, DB, DC, DD}, {2'b00, q1});
        end
        CORE_BUSY = 1'b0;
        CORE_DONE = 1'b1;
        step();
        CORE_DONE = 1'b0;
        check("b2b_done_edge", {sif.S_READY, START}, 2'b00);
        step();
        exp_cnt++;
        check("b2b_start2", {START, sif.S_READY}, 2'b11);
        check("b2b_lanes2", {DA, DB, DC, DD}, q2);
        check_cnt("b2b_q2");
        CORE_BUSY = 1'b1;
        send_bytes(q3, 4, 1'b0);
        check("b2b_ready_low2", sif.S_READY, 0);
        check("b2b_lanes2_run", {DA, DB, DC, DD}, q2);
        CORE_BUSY = 1'b0;
        CORE_DONE = 1'b1;
        step();
        CORE_DONE = 1'b0;
        step();
        exp_cnt++;
        check("b2b_start3", START, 1);
        check("b2b_lanes3", {DA, DB, DC, DD}, q3);
        check_cnt("b2b_q3");
        core_respond(3);
        check("b2b_no_errs", {ERR_PAD, ERR_TIMEOUT}, 0);

        // pad set coinciding with CLR_ERR, then no BUSY -> timeout
        CLR_ERR = 1'b1;
        send_byte(8'h5C, 1'b1);
        CLR_ERR = 1'b0;
        check("pad_set_wins", ERR_PAD, 1);
        step();
        exp_cnt++;
        check("to_start", START, 1);
        check("to_lanes", {DA, DB, DC, DD}, 32'h5C000000);
        check_cnt("to");
        step();
        step();
        step();
        check("to_not_early", ERR_TIMEOUT, 0);
        step();
        check("to_set", ERR_TIMEOUT, 1);
        CLR_ERR = 1'b1;
        step();
        CLR_ERR = 1'b0;
        check("to_cleared", {ERR_PAD, ERR_TIMEOUT}, 0);
        run_quad(vecs[5]);

        // reset while START is high, then reset with a partial quad staged
        send_bytes(32'hDEADBEEF, 4, 1'b0);
        step();
        check("rst_mid_start", START, 1);
        RST_GLO_N = 1'b0;
        #1;
        exp_cnt = '0;
        check("rst_async_drop", {START, DA, DB, DC, DD}, 0);
        check_cnt("rst_async");
        #2;
        RST_GLO_N = 1'b1;
        step();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        RST_GLO_N = 1'b0;
        #2;
        RST_GLO_N = 1'b1;
        repeat (3) step();
        check("rst_no_start", {START, sif.S_READY}, 2'b01);
        check_cnt("rst_partial");
        run_quad(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
